// File: rtl/column_sequencer.sv
// Column multiplexer for the LED panel: drives one column select at a time, then blanks.
// Optional overdrive guard is built when COLUMN_SEQ_GUARD_EN is defined.
module column_sequencer #(
  parameter int N_COLUMNS    = 8,
  parameter int DRIVE_CYCLES = 330,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                         clk_33,
  input  logic                         nrst,
  input  logic                         enable,
  input  logic                         sync,
  output logic [N_COLUMNS-1:0]         mux_out,
  output logic [$clog2(N_COLUMNS)-1:0] column_idx,
  output logic                         column_start,
  output logic                         blanking,
  output logic                         fault
);

  localparam int IDX_W      = $clog2(N_COLUMNS);
  localparam int MAX_CYC    = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);
  localparam int BLANK_LD_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_LD_I);
  localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(N_COLUMNS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  logic [1:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [N_COLUMNS-1:0] mux_reg, mux_next;
  logic                 start_reg, start_next;
  logic [IDX_W-1:0]     idx_adv;
  logic                 guard_trip;
  logic                 fault_q;

  function automatic logic [N_COLUMNS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = {{(N_COLUMNS-1){1'b0}}, 1'b1} << i;
  endfunction

  assign idx_adv = (idx_reg == LAST_COL) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    mux_next   = mux_reg;
    start_next = 1'b0;
    if (!enable || guard_trip) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      idx_next   = '0;
      mux_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // A latched overdrive fault keeps the block parked until enable drops
          if (!fault_q) begin
            state_next = S_DRIVE;
            cnt_next   = DRIVE_LOAD;
            idx_next   = '0;
            mux_next   = onehot('0);
            start_next = 1'b1;
          end
        end
        S_DRIVE, S_BLANK: begin
          if (sync) begin
            idx_next = '0;
            if (BLANK_CYCLES > 0) begin
              state_next = S_BLANK;
              cnt_next   = BLANK_LOAD;
              mux_next   = '0;
            end else begin
              state_next = S_DRIVE;
              cnt_next   = DRIVE_LOAD;
              mux_next   = onehot('0);
              start_next = 1'b1;
            end
          end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else if (state_reg == S_DRIVE && BLANK_CYCLES > 0) begin
            state_next = S_BLANK;
            cnt_next   = BLANK_LOAD;
            idx_next   = idx_adv;
            mux_next   = '0;
          end else if (state_reg == S_DRIVE) begin
            cnt_next   = DRIVE_LOAD;
            idx_next   = idx_adv;
            mux_next   = onehot(idx_adv);
            start_next = 1'b1;
          end else begin
            state_next = S_DRIVE;
            cnt_next   = DRIVE_LOAD;
            mux_next   = onehot(idx_reg);
            start_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          mux_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      mux_reg   <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      mux_reg   <= mux_next;
      start_reg <= start_next;
    end
  end

`ifdef COLUMN_SEQ_GUARD_EN
  // Run length of the currently lit column, independent of the sequencing counter
  localparam int RUN_W = $clog2(DRIVE_CYCLES + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(DRIVE_CYCLES + 1);

  logic [N_COLUMNS-1:0] mux_last_reg;
  logic [RUN_W-1:0]     run_reg, run_next;
  logic                 fault_reg, fault_next;

  always_comb begin
    run_next = '0;
    if (mux_reg != '0)
      run_next = (mux_reg == mux_last_reg) ? run_reg + 1'b1 : RUN_W'(1);
  end

  assign guard_trip = (run_next == RUN_LIMIT);
  assign fault_next = enable & (fault_reg | guard_trip);

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      mux_last_reg <= '0;
      run_reg      <= '0;
      fault_reg    <= 1'b0;
    end else begin
      mux_last_reg <= mux_reg;
      run_reg      <= run_next;
      fault_reg    <= fault_next;
    end
  end

  assign fault_q = fault_reg;
`else
  assign guard_trip = 1'b0;
  assign fault_q    = 1'b0;
`endif

  assign mux_out      = mux_reg;
  assign column_idx   = idx_reg;
  assign column_start = start_reg;
  assign blanking     = ~|mux_reg;
  assign fault        = fault_q;

endmodule

// File: tb/tb_column_sequencer.sv
// Randomized + directed bench for column_sequencer against a frame-position model.
// Two instances: N=8/D=4/B=2 and N=4/D=3/B=0.
module tb_column_sequencer;

  localparam int N_A = 8, D_A = 4, B_A = 2, P_A = N_A * (D_A + B_A);
  localparam int N_B = 4, D_B = 3, B_B = 0, P_B = N_B * (D_B + B_B);

  logic       clk_33 = 1'b0;
  logic       nrst = 1'b0;
  logic       enable_a = 1'b0, sync_a = 1'b0;
  logic       enable_b = 1'b0, sync_b = 1'b0;
  logic [7:0] mux_a;
  logic [2:0] idx_a;
  logic       start_a, blank_a, fault_a;
  logic [3:0] mux_b;
  logic [1:0] idx_b;
  logic       start_b, blank_b, fault_b;

  int checks = 0;
  int errs = 0;
  bit cmp_on = 1'b0;
  bit cmp_a_on = 1'b1;

  // model: running flag plus position within the frame
  bit run_a = 1'b0, run_b = 1'b0;
  int pos_a = 0, pos_b = 0;

  column_sequencer #(.N_COLUMNS(N_A), .DRIVE_CYCLES(D_A), .BLANK_CYCLES(B_A)) dut_a (
    .clk_33(clk_33), .nrst(nrst), .enable(enable_a), .sync(sync_a),
    .mux_out(mux_a), .column_idx(idx_a), .column_start(start_a),
    .blanking(blank_a), .fault(fault_a));

  column_sequencer #(.N_COLUMNS(N_B), .DRIVE_CYCLES(D_B), .BLANK_CYCLES(B_B)) dut_b (
    .clk_33(clk_33), .nrst(nrst), .enable(enable_b), .sync(sync_b),
    .mux_out(mux_b), .column_idx(idx_b), .column_start(start_b),
    .blanking(blank_b), .fault(fault_b));

  initial forever #5 clk_33 = ~clk_33;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mux(input int d, input int b, input bit run, input int pos);
    int col, off;
    if (!run) return 0;
    col = pos / (d + b);
    off = pos % (d + b);
    return (off < d) ? (32'd1 << col) : 32'd0;
  endfunction

  function automatic logic [31:0] m_idx(input int n, input int d, input int b, input bit run, input int pos);
    int col, off;
    if (!run) return 0;
    col = pos / (d + b);
    off = pos % (d + b);
    return (off < d) ? col : (col + 1) % n;
  endfunction

  function automatic logic [31:0] m_start(input int d, input int b, input bit run, input int pos);
    if (!run) return 0;
    return ((pos % (d + b)) == 0) ? 1 : 0;
  endfunction

  always @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      run_a <= 1'b0; pos_a <= 0;
      run_b <= 1'b0; pos_b <= 0;
    end else begin
      if (!enable_a) run_a <= 1'b0;
      else if (!run_a) begin run_a <= 1'b1; pos_a <= 0; end
      else if (sync_a) pos_a <= (B_A > 0) ? P_A - B_A : 0;
      else pos_a <= (pos_a + 1) % P_A;
      if (!enable_b) run_b <= 1'b0;
      else if (!run_b) begin run_b <= 1'b1; pos_b <= 0; end
      else if (sync_b) pos_b <= (B_B > 0) ? P_B - B_B : 0;
      else pos_b <= (pos_b + 1) % P_B;
    end
  end

  always @(negedge clk_33) begin
    if (cmp_on) begin
      if (cmp_a_on) begin
        chk("mux_a", mux_a, m_mux(D_A, B_A, run_a, pos_a));
        chk("idx_a", idx_a, m_idx(N_A, D_A, B_A, run_a, pos_a));
        chk("start_a", start_a, m_start(D_A, B_A, run_a, pos_a));
        chk("fault_a", fault_a, 0);
      end
      chk("onehot_a", ($countones(mux_a) <= 1), 1);
      chk("blank_a", blank_a, (mux_a == 0));
      chk("mux_b", mux_b, m_mux(D_B, B_B, run_b, pos_b));
      chk("idx_b", idx_b, m_idx(N_B, D_B, B_B, run_b, pos_b));
      chk("start_b", start_b, m_start(D_B, B_B, run_b, pos_b));
      chk("blank_b", blank_b, (m_mux(D_B, B_B, run_b, pos_b) == 0));
      chk("fault_b", fault_b, 0);
    end
  end

  task automatic step;
    @(posedge clk_33);
    #3;
  endtask

  logic [7:0] seq_a [49];
  logic [3:0] seq_b [13] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                             4'h8, 4'h8, 4'h8, 4'h1};

  initial begin
    int starts;
    bit found;
    #23;
    chk("rst_mux_a", mux_a, 0);
    chk("rst_blank_a", blank_a, 1);
    chk("rst_idx_a", idx_a, 0);
    chk("rst_start_a", start_a, 0);
    chk("rst_fault_a", fault_a, 0);
    chk("rst_blank_b", blank_b, 1);
    step;
    nrst = 1'b1;
    cmp_on = 1'b1;
    repeat (3) step;

    // full frame on instance A
    enable_a = 1'b1;
    starts = 0;
    for (int i = 0; i < 49; i++) begin
      step;
      seq_a[i] = mux_a;
      if (i < 48 && start_a) starts++;
    end
    chk("frame_c0", seq_a[0], 8'h01);
    chk("frame_c0_end", seq_a[3], 8'h01);
    chk("frame_gap0", seq_a[4], 8'h00);
    chk("frame_gap1", seq_a[5], 8'h00);
    chk("frame_c1", seq_a[6], 8'h02);
    chk("frame_c7", seq_a[45], 8'h80);
    chk("frame_gap7", seq_a[47], 8'h00);
    chk("frame_wrap", seq_a[48], 8'h01);
    chk("frame_starts", starts, 8);

    // sync while column 5 drives
    repeat (31) step;
    chk("pre_sync_c5", mux_a, 8'h20);
    sync_a = 1'b1;
    step;
    sync_a = 1'b0;
    chk("sync_gap0", mux_a, 8'h00);
    chk("sync_idx0", idx_a, 0);
    step;
    chk("sync_gap1", mux_a, 8'h00);
    step;
    chk("sync_c0", mux_a, 8'h01);
    chk("sync_c0_start", start_a, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("sync_c0_hold", mux_a, 8'h01);
    end
    step;
    chk("sync_c0_gap", mux_a, 8'h00);

    // enable dropped during column 3
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step;
      if (mux_a == 8'h08) found = 1'b1;
    end
    chk("find_c3", found, 1);
    enable_a = 1'b0;
    step;
    chk("dis_mux", mux_a, 8'h00);
    chk("dis_idx", idx_a, 0);
    repeat (9) step;
    enable_a = 1'b1;
    step;
    chk("reen_mux", mux_a, 8'h01);
    chk("reen_start", start_a, 1);

    // asynchronous reset mid-drive
    step;
    nrst = 1'b0;
    #1;
    chk("arst_mux", mux_a, 8'h00);
    chk("arst_blank", blank_a, 1);
    enable_a = 1'b0;
    repeat (2) step;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("post_rst_idle", mux_a, 8'h00);
    end
    enable_a = 1'b1;
    step;
    chk("post_rst_go", mux_a, 8'h01);

    // instance B: no blanking gap
    enable_b = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step;
      chk("nogap_seq", mux_b, seq_b[i]);
      chk("nogap_blank", blank_b, 0);
    end

`ifdef COLUMN_SEQ_GUARD_EN
    cmp_a_on = 1'b0;
    enable_a = 1'b0;
    step;
    enable_a = 1'b1;
    step;
    force dut_a.cnt_reg = 3'd1;
    repeat (4) step;
    chk("guard_c5_mux", mux_a, 8'h01);
    chk("guard_c5_fault", fault_a, 0);
    step;
    chk("guard_trip_fault", fault_a, 1);
    chk("guard_trip_mux", mux_a, 8'h00);
    release dut_a.cnt_reg;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("guard_hold_fault", fault_a, 1);
      chk("guard_hold_mux", mux_a, 8'h00);
    end
    enable_a = 1'b0;
    step;
    chk("guard_clear", fault_a, 0);
    cmp_a_on = 1'b1;
`endif

    // random enable / sync on both instances
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_33);
      #3;
      enable_a = ($urandom_range(0, 59) != 0);
      sync_a   = ($urandom_range(0, 29) == 0);
      enable_b = ($urandom_range(0, 59) != 0);
      sync_b   = ($urandom_range(0, 29) == 0);
`ifdef COLUMN_SEQ_GUARD_EN
      // re-syncing onto an already-lit column 0 legitimately extends its on-time
      if (mux_b[0]) sync_b = 1'b0;
`endif
    end
    step;
    step;
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
